aes_round_sequencer: RTL

Controller that owns the AES-128 round datapath. It arbitrates between the encryption and decryption engines and sequences the round-key index that drives the key selector. It also produces per-round control strobes for the state register and round logic. It sits between the Enc/Dec control front-ends and the shared key schedule / round datapath.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_rr_arbiter.sv | 38 +++
 rtl/aes_round_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and control-word layout for the AES-128 round sequencer.
// NR  : number of AES rounds; round counter spans 0..NR
// KW  : width of the round-key index (2**KW > NR)
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned KW = 4;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Registered control word presented to the datapath and key schedule.
    typedef struct packed {
        logic          enc_grant;
        logic          dec_grant;
        logic          mode;
        logic [KW-1:0] sel_key;
        logic          load_state;
        logic          round_en;
        logic          round_last;
        logic          busy;
        logic          done;
    } ctrl_t;

    // Decryption walks the key schedule backwards from NR to 0.
    function automatic logic [KW-1:0] key_index(input logic mode, input logic [KW-1:0] r);
        return (mode == MODE_ENC) ? r : (KW'(NR) - r);
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-requester round-robin arbiter for the encrypt/decrypt engines.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   enc_req     : encryption request
//   dec_req     : decryption request
//   accept      : the sequencer is starting the selected operation this cycle
//   req_any_c   : at least one request pending (combinational)
//   pick_enc_c  : 1 = encryption is the winner, 0 = decryption (combinational)
module aes_rr_arbiter
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enc_req,
    input  logic dec_req,
    input  logic accept,
    output logic req_any_c,
    output logic pick_enc_c
);

    logic last_mode;

    // On a tie the mode opposite the previous grant wins; reset favours encrypt.
    always_comb begin
        req_any_c  = enc_req | dec_req;
        pick_enc_c = enc_req & (~dec_req | (last_mode == MODE_DEC));
    end

    // Remember the mode of the last accepted operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_mode <= MODE_DEC;
        end else if (accept) begin
            last_mode <= pick_enc_c ? MODE_ENC : MODE_DEC;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round controller: arbitrates encrypt/decrypt, sequences the round-key
// index and issues per-round strobes. All outputs come straight from flops.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   EncReq, DecReq    : level requests, held until granted
//   KeyValid          : key schedule ready; gates operation start only
//   Hold              : freezes sequencing in LOAD/ROUND
//   EncGrant/DecGrant : accept pulse (stretched by Hold)
//   Mode              : 1 = encrypt, 0 = decrypt
//   SelKey            : round-key index, always within 0..NR
//   LoadState         : round-0 cycle (load + AddRoundKey)
//   RoundEn/RoundLast : full round / final round strobes
//   Busy, Done        : operation in progress / result valid pulse
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          EncReq,
    input  logic          DecReq,
    input  logic          KeyValid,
    input  logic          Hold,
    output logic          EncGrant,
    output logic          DecGrant,
    output logic          Mode,
    output logic [KW-1:0] SelKey,
    output logic          LoadState,
    output logic          RoundEn,
    output logic          RoundLast,
    output logic          Busy,
    output logic          Done
);

    state_t        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          accept;
    logic          req_any_c;
    logic          pick_enc_c;

    aes_rr_arbiter u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_req    (EncReq),
        .dec_req    (DecReq),
        .accept     (accept),
        .req_any_c  (req_any_c),
        .pick_enc_c (pick_enc_c)
    );

    // State, round counter and registered control word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state and next control word; strobes default low, Mode/SelKey hold.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        accept          = 1'b0;
        ctrl_d          = '0;
        ctrl_d.mode     = ctrl_q.mode;
        ctrl_d.sel_key  = ctrl_q.sel_key;

        case (state_q)
            ST_IDLE: begin
                if (KeyValid && req_any_c) begin
                    accept            = 1'b1;
                    state_d           = ST_LOAD;
                    cnt_d             = '0;
                    ctrl_d.mode       = pick_enc_c ? MODE_ENC : MODE_DEC;
                    ctrl_d.enc_grant  = pick_enc_c;
                    ctrl_d.dec_grant  = ~pick_enc_c;
                    ctrl_d.load_state = 1'b1;
                    ctrl_d.busy       = 1'b1;
                    ctrl_d.sel_key    = key_index(ctrl_d.mode, '0);
                end
            end
            ST_LOAD, ST_ROUND: begin
                if (Hold) begin
                    // Everything frozen, strobes included; datapath masks with ~Hold.
                    ctrl_d = ctrl_q;
                end else if (state_q == ST_ROUND && cnt_q == KW'(NR)) begin
                    state_d     = ST_DONE;
                    ctrl_d.done = 1'b1;
                end else begin
                    state_d           = ST_ROUND;
                    cnt_d             = cnt_q + KW'(1);
                    ctrl_d.round_en   = 1'b1;
                    ctrl_d.busy       = 1'b1;
                    ctrl_d.round_last = (cnt_d == KW'(NR));
                    ctrl_d.sel_key    = key_index(ctrl_q.mode, cnt_d);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign EncGrant  = ctrl_q.enc_grant;
    assign DecGrant  = ctrl_q.dec_grant;
    assign Mode      = ctrl_q.mode;
    assign SelKey    = ctrl_q.sel_key;
    assign LoadState = ctrl_q.load_state;
    assign RoundEn   = ctrl_q.round_en;
    assign RoundLast = ctrl_q.round_last;
    assign Busy      = ctrl_q.busy;
    assign Done      = ctrl_q.done;

endmodule
